regfile_wb_queue: RTL

//  Write-side initiator for the 32x32 register file's single write port.

---
 rtl/regfile_wb_queue.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue
//   Write-side initiator for the register file's single write port. Writebacks
//   from the pipeline and the multdiv unit are merged into an in-order FIFO.
//   The FIFO drains one entry per cycle onto the regfile write port. Decode-stage
//   reads that hit a queued, not yet committed, write are flagged.
//
// Ports
//   clock, ctrl_reset            clock (rising edge); async active-low reset
//   pipe_wb_valid/ready/reg/data pipeline writeback request channel
//   md_wb_valid/ready/reg/data   multdiv writeback request channel
//   ctrl_writeEnable             regfile write strobe (FIFO not empty)
//   ctrl_writeReg, data_writeReg regfile write index and data (FIFO head)
//   query_regA/B                 decode read indices
//   pendingA/B                   a queued write targets query_regA/B
//   bypass_dataA/B               data of the youngest queued write to query_regA/B
//
// Configuration
//   REGFILE_WB_BYPASS_EN: when defined, bypass_dataA/B carry forwarded data.
//   When undefined they are tied to 0 and decode must stall on pendingA/B.
//
// Handshake: a request transfers on a rising edge where valid and ready are both
// high. Ready depends only on registered occupancy (md also on pipe_wb_valid),
// never on ready of the other side. Requests to register 0 transfer normally but
// are discarded instead of queued.
module regfile_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              pipe_wb_valid,
  output logic              pipe_wb_ready,
  input  logic [ADDR_W-1:0] pipe_wb_reg,
  input  logic [DATA_W-1:0] pipe_wb_data,
  input  logic              md_wb_valid,
  output logic              md_wb_ready,
  input  logic [ADDR_W-1:0] md_wb_reg,
  input  logic [DATA_W-1:0] md_wb_data,
  output logic              ctrl_writeEnable,
  output logic [ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  input  logic [ADDR_W-1:0] query_regA,
  input  logic [ADDR_W-1:0] query_regB,
  output logic              pendingA,
  output logic              pendingB,
  output logic [DATA_W-1:0] bypass_dataA,
  output logic [DATA_W-1:0] bypass_dataB
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] regQ  [DEPTH];
  logic [DATA_W-1:0] dataQ [DEPTH];
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W-1:0]  wrPtr;
  logic [CNT_W-1:0]  count;

  logic [CNT_W-1:0]  space;
  logic              pipeEnq;
  logic              mdEnq;
  logic              popNow;
  logic [1:0]        enqCnt;
  logic [PTR_W-1:0]  mdSlot;

  // Pointer advance with wrap modulo DEPTH (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptrAdd(input logic [PTR_W-1:0] p,
                                              input int unsigned n);
    int unsigned s;
    s = 32'(p) + n;
    if (s >= 32'(DEPTH)) s = s - 32'(DEPTH);
    return PTR_W'(s);
  endfunction

  // Space comes from registered count only: an entry popped this edge does not
  // free a slot for a request in the same cycle.
  assign space         = CNT_W'(DEPTH) - count;
  assign pipe_wb_ready = (space >= CNT_W'(1));
  // md must leave room for a simultaneous pipe request, which is older.
  assign md_wb_ready   = (space >= (pipe_wb_valid ? CNT_W'(2) : CNT_W'(1)));

  assign pipeEnq = pipe_wb_valid && pipe_wb_ready && (pipe_wb_reg != '0);
  assign mdEnq   = md_wb_valid && md_wb_ready && (md_wb_reg != '0);
  assign popNow  = (count != '0);
  assign enqCnt  = {1'b0, pipeEnq} + {1'b0, mdEnq};
  assign mdSlot  = ptrAdd(wrPtr, pipeEnq ? 32'd1 : 32'd0);

  // Head drives the regfile directly; the regfile captures on the same edge
  // that pops the entry.
  assign ctrl_writeEnable = popNow;
  assign ctrl_writeReg    = regQ[rdPtr];
  assign data_writeReg    = dataQ[rdPtr];

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (popNow) rdPtr <= ptrAdd(rdPtr, 32'd1);
      wrPtr <= ptrAdd(wrPtr, 32'(enqCnt));
      count <= count + CNT_W'(enqCnt) - CNT_W'(popNow);
    end
  end

  // Storage needs no reset: an entry is only observed while inside count.
  always_ff @(posedge clock) begin
    if (pipeEnq) begin
      regQ[wrPtr]  <= pipe_wb_reg;
      dataQ[wrPtr] <= pipe_wb_data;
    end
    if (mdEnq) begin
      regQ[mdSlot]  <= md_wb_reg;
      dataQ[mdSlot] <= md_wb_data;
    end
  end

  // Scan oldest to youngest so the last match seen is the youngest write.
  always_comb begin
    logic [PTR_W-1:0] idx;
    pendingA     = 1'b0;
    pendingB     = 1'b0;
    bypass_dataA = '0;
    bypass_dataB = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = ptrAdd(rdPtr, 32'(k));
      if (CNT_W'(k) < count) begin
        if ((query_regA != '0) && (regQ[idx] == query_regA)) begin
          pendingA = 1'b1;
`ifdef REGFILE_WB_BYPASS_EN
          bypass_dataA = dataQ[idx];
`endif
        end
        if ((query_regB != '0) && (regQ[idx] == query_regB)) begin
          pendingB = 1'b1;
`ifdef REGFILE_WB_BYPASS_EN
          bypass_dataB = dataQ[idx];
`endif
        end
      end
    end
  end

endmodule
